// File: rtl/fib_run_ctrl.sv
// Run controller for the Fibonacci datapath: arms a timed run, counts prescaled ticks,
// captures the result and raises a completion pulse. Define FIB_RUN_CTRL_STALL_EN to add stall detection.
module fib_run_ctrl #(
  parameter int CLOCK_WIDTH = 6,
  parameter int STALL_LIMIT = 16
) (
  input  logic                   wb_clk_i,
  input  logic                   reset,
  input  logic                   start_i,
  input  logic                   stop_i,
  input  logic                   ack_i,
  input  logic [15:0]            run_len_i,
  input  logic [15:0]            div_i,
  input  logic [CLOCK_WIDTH-1:0] clk_sel_i,
  input  logic [29:0]            fib_val_i,
  output logic                   fib_switch_o,
  output logic [CLOCK_WIDTH-1:0] clock_sel_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   aborted_o,
  output logic                   stalled_o,
  output logic [29:0]            result_o,
  output logic [15:0]            ticks_o,
  output logic                   irq_o
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ARM     = 3'd1;
  localparam logic [2:0] S_RUN     = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  if (STALL_LIMIT < 2 || STALL_LIMIT > 255) begin : g_bad_limit
    $error("fib_run_ctrl: STALL_LIMIT must be in 2..255");
  end

  logic [2:0]             state_q,   state_d;
  logic [15:0]            run_len_q, run_len_d;
  logic [15:0]            div_q,     div_d;
  logic [15:0]            presc_q,   presc_d;
  logic [15:0]            ticks_q,   ticks_d;
  logic [CLOCK_WIDTH-1:0] clk_sel_q, clk_sel_d;
  logic [29:0]            result_q,  result_d;
  logic                   aborted_q, aborted_d;
  logic                   stalled_q, stalled_d;
  logic                   irq_q,     irq_d;
  logic                   tick;
  logic                   stall_hit;
  logic                   start_req;

  assign tick      = (state_q == S_RUN) && (presc_q == div_q);
  assign start_req = start_i && !stop_i;

`ifdef FIB_RUN_CTRL_STALL_EN
  localparam logic [7:0] STALL_LAST = 8'(STALL_LIMIT - 1);

  logic [29:0] sample_q,     sample_d;
  logic        sample_vld_q, sample_vld_d;
  logic [7:0]  stall_cnt_q,  stall_cnt_d;

  // The first tick of a run only primes the sample; compares start on the second tick.
  assign stall_hit = tick && sample_vld_q && (fib_val_i == sample_q) &&
                     (stall_cnt_q == STALL_LAST);

  always_comb begin
    sample_d     = sample_q;
    sample_vld_d = sample_vld_q;
    stall_cnt_d  = stall_cnt_q;
    if (state_q == S_ARM) begin
      sample_vld_d = 1'b0;
      stall_cnt_d  = 8'd0;
    end else if (tick) begin
      sample_d     = fib_val_i;
      sample_vld_d = 1'b1;
      stall_cnt_d  = (sample_vld_q && fib_val_i == sample_q) ? stall_cnt_q + 8'd1 : 8'd0;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (reset) begin
      sample_q     <= '0;
      sample_vld_q <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      sample_q     <= sample_d;
      sample_vld_q <= sample_vld_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end
`else
  assign stall_hit = 1'b0;
`endif

  // NOTE: every signal gets its hold value first so no path through the case infers a latch.
  always_comb begin
    state_d   = state_q;
    run_len_d = run_len_q;
    div_d     = div_q;
    presc_d   = presc_q;
    ticks_d   = ticks_q;
    clk_sel_d = clk_sel_q;
    result_d  = result_q;
    aborted_d = aborted_q;
    stalled_d = stalled_q;
    irq_d     = (state_q == S_CAPTURE);

    case (state_q)
      S_IDLE: begin
        if (start_req) state_d = S_ARM;
      end
      S_ARM: begin
        run_len_d = run_len_i;
        div_d     = div_i;
        clk_sel_d = clk_sel_i;
        ticks_d   = 16'd0;
        presc_d   = 16'd0;
        aborted_d = 1'b0;
        stalled_d = 1'b0;
        state_d   = (run_len_i == 16'd0) ? S_CAPTURE : S_RUN;
      end
      S_RUN: begin
        presc_d = tick ? 16'd0 : presc_q + 16'd1;
        if (stall_hit) begin
          stalled_d = 1'b1;
          state_d   = S_CAPTURE;
        end
        if (stop_i) begin
          aborted_d = 1'b1;
          state_d   = S_CAPTURE;
        end else if (tick) begin
          ticks_d = (ticks_q == 16'hFFFF) ? ticks_q : ticks_q + 16'd1;
          if (ticks_q + 16'd1 == run_len_q) state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        result_d = fib_val_i;
        state_d  = S_DONE;
      end
      S_DONE: begin
        if (start_req)  state_d = S_ARM;
        else if (ack_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge wb_clk_i) begin
    if (reset) begin
      state_q   <= S_IDLE;
      run_len_q <= '0;
      div_q     <= '0;
      presc_q   <= '0;
      ticks_q   <= '0;
      clk_sel_q <= CLOCK_WIDTH'(1);
      result_q  <= '0;
      aborted_q <= 1'b0;
      stalled_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_len_q <= run_len_d;
      div_q     <= div_d;
      presc_q   <= presc_d;
      ticks_q   <= ticks_d;
      clk_sel_q <= clk_sel_d;
      result_q  <= result_d;
      aborted_q <= aborted_d;
      stalled_q <= stalled_d;
      irq_q     <= irq_d;
    end
  end

  assign fib_switch_o = (state_q == S_ARM) || (state_q == S_RUN);
  assign busy_o       = fib_switch_o || (state_q == S_CAPTURE);
  assign done_o       = (state_q == S_DONE);
  assign clock_sel_o  = clk_sel_q;
  assign aborted_o    = aborted_q;
  assign stalled_o    = stalled_q;
  assign result_o     = result_q;
  assign ticks_o      = ticks_q;
  assign irq_o        = irq_q;

endmodule

// File: tb/tb_fib_run_ctrl.sv
// Directed self-checking bench for fib_run_ctrl: timed runs, prescaling, abort,
// zero-length runs, start/stop arbitration, the long constant-value run and mid-run reset.
module tb_fib_run_ctrl;

  logic        wb_clk_i = 1'b0;
  logic        reset;
  logic        start_i, stop_i, ack_i;
  logic [15:0] run_len_i, div_i;
  logic [5:0]  clk_sel_i;
  logic [29:0] fib_val_i;
  logic        fib_switch_o;
  logic [5:0]  clock_sel_o;
  logic        busy_o, done_o, aborted_o, stalled_o, irq_o;
  logic [29:0] result_o;
  logic [15:0] ticks_o;

  int errors = 0;
  int checks = 0;

  fib_run_ctrl #(.CLOCK_WIDTH(6), .STALL_LIMIT(16)) dut (
    .wb_clk_i    (wb_clk_i),
    .reset       (reset),
    .start_i     (start_i),
    .stop_i      (stop_i),
    .ack_i       (ack_i),
    .run_len_i   (run_len_i),
    .div_i       (div_i),
    .clk_sel_i   (clk_sel_i),
    .fib_val_i   (fib_val_i),
    .fib_switch_o(fib_switch_o),
    .clock_sel_o (clock_sel_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .aborted_o   (aborted_o),
    .stalled_o   (stalled_o),
    .result_o    (result_o),
    .ticks_o     (ticks_o),
    .irq_o       (irq_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic step();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      $error("check %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_switch"},  32'(fib_switch_o), 32'd0);
    check({tag, "_clksel"},  32'(clock_sel_o),  32'd1);
    check({tag, "_busy"},    32'(busy_o),       32'd0);
    check({tag, "_done"},    32'(done_o),       32'd0);
    check({tag, "_aborted"}, 32'(aborted_o),    32'd0);
    check({tag, "_stalled"}, 32'(stalled_o),    32'd0);
    check({tag, "_irq"},     32'(irq_o),        32'd0);
    check({tag, "_result"},  32'(result_o),     32'd0);
    check({tag, "_ticks"},   32'(ticks_o),      32'd0);
  endtask

  initial begin
    int sw_cnt;
    int irq_cnt;
    int run_cycles;
    logic [15:0] tk [0:15];

    reset = 1'b1; start_i = 1'b0; stop_i = 1'b0; ack_i = 1'b0;
    run_len_i = '0; div_i = '0; clk_sel_i = '0; fib_val_i = '0;
    for (int i = 0; i < 16; i++) tk[i] = '0;
    step(); step();
    reset = 1'b0;
    check_reset_values("rst");

    // Five-tick run, div 0: ARM plus five RUN cycles with the switch on, one irq.
    run_len_i = 16'd5; div_i = 16'd0; clk_sel_i = 6'h04; fib_val_i = 30'h0123_4567;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    sw_cnt = 0; irq_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (fib_switch_o) sw_cnt++;
      if (irq_o) irq_cnt++;
      step();
    end
    check("r5_switch_cycles", 32'(sw_cnt), 32'd6);
    check("r5_irq_pulses",    32'(irq_cnt), 32'd1);
    check("r5_clock_sel",     32'(clock_sel_o), 32'h04);
    check("r5_ticks",         32'(ticks_o), 32'd5);
    check("r5_result",        32'(result_o), 32'h0123_4567);
    check("r5_done_held",     32'(done_o), 32'd1);

    // Restart straight from DONE with div 2: one tick every three RUN cycles.
    run_len_i = 16'd3; div_i = 16'd2; clk_sel_i = 6'h09; fib_val_i = 30'h2AAA_5555;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    check("d2_arm_switch", 32'(fib_switch_o), 32'd1);
    run_cycles = 0;
    for (int k = 1; k < 16; k++) begin
      step();
      if (!fib_switch_o) break;
      tk[k] = ticks_o;
      run_cycles = k;
    end
    check("d2_run_cycles",   32'(run_cycles), 32'd9);
    check("d2_ticks_at_r3",  32'(tk[3]), 32'd0);
    check("d2_ticks_at_r4",  32'(tk[4]), 32'd1);
    check("d2_ticks_at_r7",  32'(tk[7]), 32'd2);
    check("d2_capture_busy", 32'(busy_o), 32'd1);
    check("d2_capture_tick", 32'(ticks_o), 32'd3);
    step();
    check("d2_irq_first", 32'(irq_o), 32'd1);
    check("d2_done",      32'(done_o), 32'd1);
    step(); step(); step();
    check("d2_irq_once",   32'(irq_o), 32'd0);
    check("d2_done_hold",  32'(done_o), 32'd1);
    check("d2_result",     32'(result_o), 32'h2AAA_5555);
    ack_i = 1'b1;
    step();
    ack_i = 1'b0;
    check("d2_ack_done",    32'(done_o), 32'd0);
    check("d2_ack_busy",    32'(busy_o), 32'd0);
    check("d2_clksel_keep", 32'(clock_sel_o), 32'h09);

    // Abort: stop during the second tick, which must not be counted.
    run_len_i = 16'd100; div_i = 16'd0; clk_sel_i = 6'h11; fib_val_i = 30'h0000_0ABC;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    step();
    step();
    stop_i = 1'b1;
    step();
    stop_i = 1'b0;
    check("ab_switch_off", 32'(fib_switch_o), 32'd0);
    check("ab_aborted",    32'(aborted_o), 32'd1);
    check("ab_ticks",      32'(ticks_o), 32'd1);
    step();
    check("ab_irq",    32'(irq_o), 32'd1);
    check("ab_result", 32'(result_o), 32'h0000_0ABC);
    ack_i = 1'b1;
    step();
    ack_i = 1'b0;

    // Zero-length run: ARM goes straight to CAPTURE.
    run_len_i = 16'd0; fib_val_i = 30'h0000_0777;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    check("z_arm_switch", 32'(fib_switch_o), 32'd1);
    step();
    check("z_cap_switch", 32'(fib_switch_o), 32'd0);
    check("z_cap_busy",   32'(busy_o), 32'd1);
    step();
    check("z_irq",     32'(irq_o), 32'd1);
    check("z_ticks",   32'(ticks_o), 32'd0);
    check("z_aborted", 32'(aborted_o), 32'd0);
    ack_i = 1'b1;
    step();
    ack_i = 1'b0;

    // start and stop together in IDLE: stop wins.
    start_i = 1'b1; stop_i = 1'b1;
    step();
    start_i = 1'b0; stop_i = 1'b0;
    check("ss_busy",   32'(busy_o), 32'd0);
    check("ss_switch", 32'(fib_switch_o), 32'd0);
    step();
    check("ss_busy2",  32'(busy_o), 32'd0);

    // Long run with a constant datapath value.
    run_len_i = 16'd1000; div_i = 16'd0; fib_val_i = 30'h0000_1111;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    for (int i = 0; i < 1200; i++) begin
      if (done_o) break;
      step();
    end
    check("long_done", 32'(done_o), 32'd1);
`ifdef FIB_RUN_CTRL_STALL_EN
    check("long_ticks",   32'(ticks_o), 32'd17);
    check("long_stalled", 32'(stalled_o), 32'd1);
`else
    check("long_ticks",   32'(ticks_o), 32'd1000);
    check("long_stalled", 32'(stalled_o), 32'd0);
`endif
    check("long_aborted", 32'(aborted_o), 32'd0);
    ack_i = 1'b1;
    step();
    ack_i = 1'b0;

    // start during RUN is ignored; then reset mid-run.
    run_len_i = 16'd50; div_i = 16'd0; fib_val_i = 30'h0000_0042;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    step();
    step();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    step();
    check("sr_ticks",  32'(ticks_o), 32'd3);
    check("sr_switch", 32'(fib_switch_o), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_reset_values("midrst");
    step();
    check("midrst_irq_after",  32'(irq_o), 32'd0);
    check("midrst_done_after", 32'(done_o), 32'd0);
    check("midrst_busy_after", 32'(busy_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
